sub32_seq: RTL and testbench



---
 rtl/sub32_seq.sv | 121 ++++++++++++
 tb/tb_sub32_seq.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/sub32_seq.sv
// sub32_seq -- multi-cycle 32-bit subtractor, s = a - b - bi (mod 2^32).
// One shared 4-bit ripple slice adds ~b with carry-in ~bi, processing one
// slice per clock from least to most significant (8 clocks per operation).
//
// state | meaning
// IDLE  | waiting for start; result outputs hold the last operation's values
// RUN   | writing slice cnt of s each clock (cnt = 0..7)
// DONE  | one-cycle done pulse; a start here is accepted immediately
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-high reset
//   start  in   request, accepted in IDLE or DONE
//   a, b   in   32-bit minuend / subtrahend, latched on accept
//   bi     in   borrow-in, latched on accept
//   s      out  32-bit difference
//   bo     out  borrow-out (unsigned a < b + bi)
//   ovf    out  signed overflow
//   busy   out  high in RUN and DONE
//   done   out  one-cycle pulse, results valid
module sub32_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        bi,
  output logic [31:0] s,
  output logic        bo,
  output logic        ovf,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] ra;
  logic [31:0] rnb;
  logic        c;
  logic [2:0]  cnt;

  logic [4:0]  slice_sum;
  logic [4:0]  slice_base;

  assign slice_base = {cnt, 2'b00};

  always_comb begin
    slice_sum = {1'b0, ra[slice_base +: 4]} + {1'b0, rnb[slice_base +: 4]}
              + {4'b0000, c};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ra    <= 32'd0;
      rnb   <= 32'd0;
      c     <= 1'b0;
      cnt   <= 3'd0;
      s     <= 32'd0;
      bo    <= 1'b0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            ra    <= a;
            rnb   <= ~b;
            c     <= ~bi;
            cnt   <= 3'd0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end

        RUN: begin
          s[slice_base +: 4] <= slice_sum[3:0];
          c   <= slice_sum[4];
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            // Final slice: slice_sum[3] is the new s[31].
            bo    <= ~slice_sum[4];
            ovf   <= (ra[31] ^ ~rnb[31]) & (slice_sum[3] ^ ra[31]);
            done  <= 1'b1;
            state <= DONE;
          end
        end

        DONE: begin
          done <= 1'b0;
          // Accepting here keeps back-to-back operations at 9 cycles each.
          if (start) begin
            ra    <= a;
            rnb   <= ~b;
            c     <= ~bi;
            cnt   <= 3'd0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub32_seq.sv
// tb_sub32_seq -- directed self-checking bench for sub32_seq.
module tb_sub32_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        bi;
  logic [31:0] s;
  logic        bo;
  logic        ovf;
  logic        busy;
  logic        done;

  int compared;
  int mismatched;

  sub32_seq dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .bi    (bi),
    .s     (s),
    .bo    (bo),
    .ovf   (ovf),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one operation from IDLE and checks latency, busy length and results.
  task automatic run_op(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                        input logic ibi, input logic [31:0] es, input logic ebo,
                        input logic eovf);
    int lat;
    int bcnt;
    a = ia; b = ib; bi = ibi; start = 1'b1;
    tick();                       // E0
    start = 1'b0;
    chk({tag, "_busy_e0"}, {31'd0, busy}, 32'd1);
    lat  = 0;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
      if (busy) bcnt++;
    end
    chk({tag, "_latency"}, lat, 8);
    chk({tag, "_s"}, s, es);
    chk({tag, "_bo"}, {31'd0, bo}, {31'd0, ebo});
    chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eovf});
    chk({tag, "_busy_cycles"}, bcnt, 9);
    tick();                       // E9
    chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done_after"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int lat;
    logic [32:0] ref33;
    longint      sd;
    logic [31:0] ea;
    logic [31:0] eb;
    logic        ebi;
    logic [31:0] exp_s;
    logic        exp_bo;
    logic        exp_ovf;

    compared = 0;
    mismatched = 0;
    reset = 1'b1; start = 1'b0; a = 32'd0; b = 32'd0; bi = 1'b0;
    repeat (2) tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_s", s, 32'd0);
    chk("rst_bo_ovf", {30'd0, bo, ovf}, 32'd0);
    reset = 1'b0;
    tick();

    run_op("t5m3", 32'd5, 32'd3, 1'b0, 32'h00000002, 1'b0, 1'b0);
    run_op("t3m5", 32'd3, 32'd5, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0);
    run_op("t0m0b1", 32'd0, 32'd0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    run_op("tminm1", 32'h80000000, 32'd1, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1);
    run_op("tmaxmn1", 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1);

    // Start and input changes during RUN must not disturb the operation.
    a = 32'h12345678; b = 32'h11111111; bi = 1'b0; start = 1'b1;
    tick();                       // E0
    start = 1'b0;
    a = 32'hDEADBEEF; b = 32'h0BADF00D; bi = 1'b1;
    tick(); tick(); tick();       // E1..E3
    start = 1'b1; a = 32'd0; b = 32'd1;
    lat = 3;
    tick();
    lat++;
    start = 1'b0; a = 32'hA5A5A5A5; b = 32'h5A5A5A5A;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    chk("midrun_latency", lat, 8);
    chk("midrun_s", s, 32'h01234567);
    chk("midrun_bo_ovf", {30'd0, bo, ovf}, 32'd0);
    tick();
    chk("midrun_idle", {31'd0, busy}, 32'd0);

    // Asynchronous reset in the middle of an operation.
    a = 32'hFFFF0000; b = 32'h0000FFFF; bi = 1'b1; start = 1'b1;
    tick();                       // E0
    start = 1'b0;
    repeat (4) tick();            // E4
    chk("prerst_busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("asyncrst_busy_done", {30'd0, busy, done}, 32'd0);
    chk("asyncrst_s", s, 32'd0);
    chk("asyncrst_bo_ovf", {30'd0, bo, ovf}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    run_op("t10m4", 32'd10, 32'd4, 1'b0, 32'd6, 1'b0, 1'b0);

    // Back-to-back with start held high: one done every 9 cycles.
    ea = $urandom; eb = $urandom; ebi = 1'($urandom_range(0, 1));
    a = ea; b = eb; bi = ebi; start = 1'b1;
    tick();                       // first accept
    for (int i = 0; i < 1000; i++) begin
      ref33   = {1'b0, ea} - {1'b0, eb} - {32'd0, ebi};
      exp_s   = ref33[31:0];
      exp_bo  = ref33[32];
      sd      = longint'($signed(ea)) - longint'($signed(eb)) - longint'(ebi);
      exp_ovf = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
      lat = 0;
      while (!done && lat < 20) begin
        tick();
        lat++;
      end
      chk("b2b_latency", lat, 8);
      chk("b2b_s", s, exp_s);
      chk("b2b_bo", {31'd0, bo}, {31'd0, exp_bo});
      chk("b2b_ovf", {31'd0, ovf}, {31'd0, exp_ovf});
      ea = $urandom; eb = $urandom; ebi = 1'($urandom_range(0, 1));
      a = ea; b = eb; bi = ebi;
      if (i == 999) start = 1'b0;
      tick();                     // accept edge of the next operation
      chk("b2b_busy", {31'd0, busy}, (i == 999) ? 32'd0 : 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
